// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: exception causes, fetch state encoding, reset vector
package pipeline_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  localparam logic [3:0] ECAUSE_MISALIGNED = 4'd0;
  localparam logic [3:0] ECAUSE_ILLEGAL    = 4'd2;
  localparam logic [3:0] ECAUSE_EBREAK     = 4'd3;
  localparam logic [3:0] ECAUSE_ECALL      = 4'd11;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_HOLD  = 2'd2,
    FETCH_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// rtl/fetch_hold_buffer.sv - one-entry {pc, data} buffer for a response that arrives while decode is stalled
module fetch_hold_buffer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_data,
  input  logic        drain,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] data
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    data_d  = data_q;
    if (flush || drain) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      data_d  = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign data  = data_q;

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage: PC, single-outstanding imem requests, fetch->decode register
// FETCH_MISALIGN_CHECK_EN: misaligned redirect target raises a fetch exception instead of being cleared.
module fetch
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        invalidate,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out,
  output logic [31:0] next_pc_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        exception_out,
  output logic [3:0]  ecause_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         discard_q, discard_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic [31:0]  next_pc_out_q, next_pc_out_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;

  logic         req_valid, accept, outstanding, present;
  logic [31:0]  req_addr, target, pres_pc, pres_data;
  logic         hb_load, hb_drain, hb_flush, hb_valid;
  logic [31:0]  hb_pc, hb_data;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic         fault_pend_q, fault_pend_d;
  logic         exc_q, exc_d, pres_exc;
  logic [3:0]   ecause_q, ecause_d;
  logic         misaligned;

  assign target     = redirect_target;
  assign misaligned = |redirect_target[1:0];
`else
  assign target = redirect_target & ~32'h3;
`endif

  // Back-to-back issue only when the arriving word is actually handed to decode.
  always_comb begin
    req_valid = 1'b0;
    req_addr  = pc_q;
    if (state_q == FETCH_REQ) begin
      req_valid = !discard_q;
    end else if (state_q == FETCH_WAIT && imem_rsp_valid && !discard_q && !stall &&
                 !invalidate && !redirect_valid) begin
      req_valid = 1'b1;
      req_addr  = pc_plus4(pc_q);
    end
  end

  assign accept      = req_valid && imem_req_ready;
  assign outstanding = accept || ((state_q == FETCH_WAIT || discard_q) && !imem_rsp_valid);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    discard_d     = discard_q;
    pc_out_d      = pc_out_q;
    next_pc_out_d = next_pc_out_q;
    instr_d       = instr_q;
    valid_d       = valid_q;
    hb_load       = 1'b0;
    hb_drain      = 1'b0;
    hb_flush      = 1'b0;
    present       = 1'b0;
    pres_pc       = pc_q;
    pres_data     = imem_rsp_data;
`ifdef FETCH_MISALIGN_CHECK_EN
    fault_pend_d  = fault_pend_q;
    exc_d         = exc_q;
    ecause_d      = ecause_q;
    pres_exc      = 1'b0;
`endif

    if (redirect_valid) begin
      pc_d      = target;
      hb_flush  = 1'b1;
      discard_d = outstanding;
      state_d   = outstanding ? FETCH_WAIT : FETCH_REQ;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_d = misaligned;
      if (misaligned) begin
        state_d = FETCH_FAULT;
      end
`endif
    end else begin
      if (imem_rsp_valid && discard_q) begin
        discard_d = 1'b0;
      end
      case (state_q)
        FETCH_REQ: begin
          if (accept) begin
            state_d = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_rsp_valid) begin
            if (discard_q) begin
              state_d = FETCH_REQ;
            end else if (stall) begin
              hb_load = 1'b1;
              state_d = FETCH_HOLD;
            end else if (invalidate) begin
              state_d = FETCH_REQ;
            end else begin
              present = 1'b1;
              pc_d    = pc_plus4(pc_q);
              state_d = accept ? FETCH_WAIT : FETCH_REQ;
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall) begin
            hb_drain = 1'b1;
            state_d  = FETCH_REQ;
            if (!invalidate && hb_valid) begin
              present   = 1'b1;
              pres_pc   = hb_pc;
              pres_data = hb_data;
              pc_d      = pc_plus4(hb_pc);
            end
          end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        FETCH_FAULT: begin
          if (fault_pend_q && !stall && !invalidate) begin
            present      = 1'b1;
            pres_exc     = 1'b1;
            pres_data    = '0;
            fault_pend_d = 1'b0;
          end
        end
`endif
        default: state_d = FETCH_REQ;
      endcase
    end

    // Decode-facing register only moves on a non-stalled edge.
    if (!stall) begin
      valid_d = present;
      if (present) begin
        pc_out_d      = pres_pc;
        next_pc_out_d = pc_plus4(pres_pc);
        instr_d       = pres_data;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      exc_d = present && pres_exc;
      if (present && pres_exc) begin
        ecause_d = ECAUSE_MISALIGNED;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= FETCH_REQ;
      pc_q          <= RESET_VECTOR;
      discard_q     <= outstanding;
      pc_out_q      <= '0;
      next_pc_out_q <= '0;
      instr_q       <= '0;
      valid_q       <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_q  <= 1'b0;
      exc_q         <= 1'b0;
      ecause_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      discard_q     <= discard_d;
      pc_out_q      <= pc_out_d;
      next_pc_out_q <= next_pc_out_d;
      instr_q       <= instr_d;
      valid_q       <= valid_d;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_pend_q  <= fault_pend_d;
      exc_q         <= exc_d;
      ecause_q      <= ecause_d;
`endif
    end
  end

  fetch_hold_buffer u_hold (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (hb_load),
    .load_pc   (pc_q),
    .load_data (imem_rsp_data),
    .drain     (hb_drain),
    .flush     (hb_flush),
    .valid     (hb_valid),
    .pc        (hb_pc),
    .data      (hb_data)
  );

  assign imem_req_valid  = req_valid;
  assign imem_addr       = req_addr;
  assign pc_out          = pc_out_q;
  assign next_pc_out     = next_pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign exception_out   = exc_q;
  assign ecause_out      = ecause_q;
`else
  assign exception_out   = 1'b0;
  assign ecause_out      = 4'd0;
`endif

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - scoreboard bench for fetch with a 1/2-cycle latency instruction memory model
module tb_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_addr, imem_rsp_data;
  logic        stall, invalidate, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_out, next_pc_out, instruction_out;
  logic        valid_out, exception_out;
  logic [3:0]  ecause_out;

  always #5 clk = ~clk;

  fetch #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .stall           (stall),
    .invalidate      (invalidate),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc_out          (pc_out),
    .next_pc_out     (next_pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out),
    .exception_out   (exception_out),
    .ecause_out      (ecause_out)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: accepts up to acc_limit requests in total, answers after 1 or 2 cycles.
  int          acc_count = 0;
  int          acc_limit = 0;
  logic        lat2 = 1'b0;
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [31:0] p1_a = '0, p2_a = '0;

  assign imem_req_ready = (acc_count < acc_limit);
  assign imem_rsp_valid = lat2 ? p2_v : p1_v;
  assign imem_rsp_data  = mem_word(lat2 ? p2_a : p1_a);

  always @(posedge clk) begin
    if (imem_req_valid && imem_req_ready) acc_count <= acc_count + 1;
    p1_v <= imem_req_valid && imem_req_ready;
    p1_a <= imem_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   pop_cyc[$];

  task automatic push_exp(input logic [31:0] pc, input logic exc);
    exp_t e;
    e.pc    = pc;
    e.instr = exc ? 32'h0 : mem_word(pc);
    e.exc   = exc;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // A presented word is taken by decode on any non-stalled edge.
  always @(negedge clk) begin
    if (reset_n && valid_out && !stall) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual pc_out=%h expected none", pc_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pc_out", pc_out, mon_e.pc);
        chk("next_pc_out", next_pc_out, mon_e.pc + 32'd4);
        chk("instruction_out", instruction_out, mon_e.instr);
        chk("exception_out", {31'd0, exception_out}, {31'd0, mon_e.exc});
        chk("ecause_out", {28'd0, ecause_out}, 32'd0);
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n);
    int t;
    t = 0;
    while (acc_count < n && t < 20) begin
      tick();
      t++;
    end
    chk("accept_reached", {31'd0, acc_count >= n}, 32'd1);
  endtask

  task automatic wait_present(input logic [31:0] pc);
    int t;
    t = 0;
    while (!(valid_out && pc_out == pc) && t < 20) begin
      tick();
      t++;
    end
    chk("present_reached", pc_out, pc);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      tick();
      t++;
    end
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    stall = 1'b0;
    invalidate = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;
    tick();
    tick();
    reset_n = 1'b1;
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_pc_out", pc_out, 32'd0);
    chk("reset_next_pc_out", next_pc_out, 32'd0);
    chk("reset_instruction_out", instruction_out, 32'd0);
    chk("reset_exception_out", {31'd0, exception_out}, 32'd0);
    chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("reset_imem_addr", imem_addr, 32'h100);

    // Streaming, zero-wait memory
    push_exp(32'h100, 1'b0);
    push_exp(32'h104, 1'b0);
    push_exp(32'h108, 1'b0);
    acc_limit = 3;
    drain();
    chk("stream_back_to_back", pop_cyc[2] - pop_cyc[0], 32'd2);
    chk("idle_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("idle_imem_addr", imem_addr, 32'h10C);

    // Stall while the next response lands in the hold buffer
    push_exp(32'h10C, 1'b0);
    push_exp(32'h110, 1'b0);
    acc_limit = 5;
    wait_present(32'h10C);
    stall = 1'b1;
    tick();
    tick();
    tick();
    chk("stall_hold_valid", {31'd0, valid_out}, 32'd1);
    chk("stall_hold_pc", pc_out, 32'h10C);
    chk("stall_no_request", {31'd0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    drain();
    chk("after_stall_addr", imem_addr, 32'h114);

    // Redirect with a request outstanding (2-cycle memory)
    lat2 = 1'b1;
    acc_limit = 6;
    wait_acc(6);
    redirect_valid = 1'b1;
    redirect_target = 32'h200;
    chk("redirect_cycle_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    push_exp(32'h200, 1'b0);
    acc_limit = 7;
    chk("discard_cycle_no_req", {31'd0, imem_req_valid}, 32'd0);
    tick();
    chk("redirect_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("redirect_req_addr", imem_addr, 32'h200);
    drain();

    // Invalidate on the edge that delivers 0x204: refetched, presented once
    lat2 = 1'b0;
    acc_limit = 8;
    wait_acc(8);
    invalidate = 1'b1;
    tick();
    invalidate = 1'b0;
    chk("invalidate_valid_out", {31'd0, valid_out}, 32'd0);
    chk("invalidate_refetch_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("invalidate_refetch_addr", imem_addr, 32'h204);
    push_exp(32'h204, 1'b0);
    acc_limit = 9;
    drain();

    // Reset while a request is outstanding; the stale response must be ignored
    lat2 = 1'b1;
    acc_limit = 10;
    wait_acc(10);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("midreset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("midreset_pc_out", pc_out, 32'd0);
    chk("midreset_instruction_out", instruction_out, 32'd0);
    push_exp(32'h100, 1'b0);
    acc_limit = 11;
    drain();
    chk("after_midreset_addr", imem_addr, 32'h104);

`ifdef FETCH_MISALIGN_CHECK_EN
    push_exp(32'h202, 1'b1);
    redirect_valid = 1'b1;
    redirect_target = 32'h202;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("fault_no_request", {31'd0, imem_req_valid}, 32'd0);
      tick();
    end
    push_exp(32'h300, 1'b0);
    redirect_valid = 1'b1;
    redirect_target = 32'h300;
    acc_limit = 12;
    tick();
    redirect_valid = 1'b0;
    drain();
`else
    push_exp(32'h300, 1'b0);
    redirect_valid = 1'b1;
    redirect_target = 32'h302;
    tick();
    redirect_valid = 1'b0;
    chk("unaligned_target_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("unaligned_target_cleared", imem_addr, 32'h300);
    acc_limit = 12;
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

endmodule
